sr_cmd_gen: RTL

Front-end command generator for the SR flip-flop stage. It takes two raw, bouncy push-button inputs (set and reset), synchronises and debounces them, and detects their press (rising) edges. It emits single-cycle SR command codes on a 2-bit bus that connects directly to the flip-flop's SR input. The block never drives the illegal 2'b11 code: simultaneous requests are dropped and flagged instead.

---
 rtl/sr_cmd_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: synchronises and debounces two push buttons, detects their
// press edges and turns them into single-cycle SR commands for the SR
// flip-flop stage. Colliding set/reset requests are dropped and flagged on
// 'conflict', so the illegal code 2'b11 is never driven.
module sr_cmd_gen #(
    parameter int DB_CYCLES = 1000,
    parameter int HOLDOFF   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_set,
    input  logic       btn_rst,
    output logic [1:0] SR,
    output logic       conflict,
    output logic       busy,
    output logic       set_db,
    output logic       rst_db
);

    // Channel 0 carries the set button, channel 1 the reset button.
    localparam int CW = $clog2(DB_CYCLES);
    localparam int GW = $clog2(HOLDOFF + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(HOLDOFF - 1);

    localparam logic [1:0] CODE_SET  = 2'b10;
    localparam logic [1:0] CODE_RST  = 2'b01;
    localparam logic [1:0] CODE_HOLD = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP
    } state_t;

    state_t          state;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      db;
    logic [1:0]      db_q;
    logic [CW-1:0]   cnt [2];
    logic [1:0]      pend;
    logic [GW-1:0]   gap_cnt;
    logic [1:0]      rise;
    logic [1:0]      req;

    // Two-flop synchroniser per button; only s2 is used downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {btn_rst, btn_set};
            s2 <= s1;
        end
    end

    // Debouncer: the level flips only after s2 has disagreed with it for
    // DB_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed debounced level, used to find the press (rising) edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q <= '0;
        end else begin
            db_q <= db;
        end
    end

    assign rise = db & ~db_q;
    assign req  = rise | pend;

    // Command FSM: issue one code per request, then enforce the idle gap;
    // presses arriving while busy are remembered in a one-deep pending bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            SR       <= CODE_HOLD;
            conflict <= 1'b0;
            pend     <= '0;
            gap_cnt  <= '0;
        end else begin
            SR       <= CODE_HOLD;
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (req == 2'b11) begin
                        conflict <= 1'b1;
                        pend     <= '0;
                    end else if (req[0]) begin
                        SR      <= CODE_SET;
                        pend[0] <= 1'b0;
                        state   <= CMD;
                    end else if (req[1]) begin
                        SR      <= CODE_RST;
                        pend[1] <= 1'b0;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    pend    <= pend | rise;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    pend <= pend | rise;
                    if (gap_cnt == GAP_MAX) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign set_db = db[0];
    assign rst_db = db[1];

endmodule
